mul_div_unit: RTL and testbench

Iterative unsigned multiply/divide unit for the single-cycle/multi-cycle CPU datapath. Takes two operands read from the register file's A/B read ports, runs a WIDTH-cycle shift-add multiply or restoring divide, holds the 2×WIDTH result in HI/LO, and writes LO back through the register file write port (W_Addr/W_Data/Write_Reg). Sits between register file read outputs and its write input, alongside the ALU.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_iter_core.sv | 68 ++++++
 rtl/mul_div_unit.sv | 116 +++++++++++
 tb/tb_mul_div_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply, and restoring divide when DIV_EN is defined.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic             step,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   sum;

`ifdef DIV_EN
    logic [WIDTH:0] rem;
`else
    logic unused_op;
    assign unused_op = op;
`endif

    // {hi,lo} is the shared accumulator; lo shifts out multiplier bits or in quotient bits
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
`ifdef DIV_EN
        rem = {hi, lo[WIDTH-1]};
        if (op == OP_DIVU) begin
            if (rem >= {1'b0, b_q}) begin
                hi_nxt = WIDTH'(rem - {1'b0, b_q});
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = rem[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hi  <= '0;
            lo  <= '0;
            b_q <= '0;
        end else if (clear) begin
            hi <= '0;
            lo <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a;
            b_q <= b;
        end else if (step) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned MULTU/DIVU with register-file write-back of LO.
// Define DIV_EN to build the divider; otherwise DIVU completes immediately with a zero result.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Op,
    input  logic [WIDTH-1:0]  Src_A,
    input  logic [WIDTH-1:0]  Src_B,
    input  logic [ADDR_W-1:0] Dst_Addr,
    output logic              Busy,
    output logic              Done,
    output logic [WIDTH-1:0]  HI,
    output logic [WIDTH-1:0]  LO,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [WIDTH-1:0]  W_Data,
    output logic              Write_Reg
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic             accept;
    logic             bypass;
    logic             load;
    logic             clear;
    logic             step;

    assign accept = (state == IDLE) && Start;

    // Without the divider a DIVU request skips RUN and returns zeros
`ifdef DIV_EN
    assign bypass = 1'b0;
`else
    assign bypass = (Op == OP_DIVU);
`endif

    assign load   = accept && !bypass;
    assign clear  = accept && bypass;
    assign step   = (state == RUN);
    assign W_Data = LO;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MULTU;
            W_Addr    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Write_Reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done      <= 1'b0;
                    Write_Reg <= 1'b0;
                    if (Start) begin
                        W_Addr <= Dst_Addr;
                        op_q   <= Op;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        if (bypass) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        Done      <= 1'b1;
                        Write_Reg <= (W_Addr != '0);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    Busy      <= 1'b0;
                    Done      <= 1'b0;
                    Write_Reg <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    Busy      <= 1'b0;
                    Done      <= 1'b0;
                    Write_Reg <= 1'b0;
                end
            endcase
        end
    end

    mdu_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .load   (load),
        .clear  (clear),
        .step   (step),
        .op     (op_q),
        .a      (Src_A),
        .b      (Src_B),
        .hi     (HI),
        .lo     (LO)
    );

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table, random ops through a scoreboard, and reset/Start corner cases.
module tb_mul_div_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;

    logic          Clk;
    logic          Reset_n;
    logic          Start;
    logic          Op;
    logic [W-1:0]  Src_A;
    logic [W-1:0]  Src_B;
    logic [AW-1:0] Dst_Addr;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;
    logic [AW-1:0] W_Addr;
    logic [W-1:0]  W_Data;
    logic          Write_Reg;

    mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op),
        .Src_A(Src_A), .Src_B(Src_B), .Dst_Addr(Dst_Addr),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO),
        .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic          op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] addr;
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
        logic          wr;
    } vec_t;

    typedef struct {
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
        logic [AW-1:0] addr;
        logic          wr;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [AW-1:0] addr, input logic [W-1:0] hi,
                                input logic [W-1:0] lo);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.addr = addr;
        v.hi = hi; v.lo = lo; v.wr = (addr != 0);
        return v;
    endfunction

    // Expected outcome of a request; without the divider DIVU finishes in one cycle with zeros
    task automatic push_exp(input vec_t v);
        exp_t e;
        e.hi = v.hi; e.lo = v.lo; e.addr = v.addr; e.wr = v.wr; e.lat = W + 1;
`ifndef DIV_EN
        if (v.op) begin
            e.hi = '0; e.lo = '0; e.wr = 1'b0; e.lat = 1;
        end
`endif
        sb.push_back(e);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int   n;
        exp_t e;
        push_exp(v);
        @(negedge Clk);
        Start = 1'b1; Op = v.op; Src_A = v.a; Src_B = v.b; Dst_Addr = v.addr;
        @(negedge Clk);
        Start = 1'b0; Src_A = $urandom; Src_B = $urandom; Dst_Addr = AW'($urandom);
        n = 1;
        check({tag, ".busy_c1"}, 64'(Busy), 64'd1);
        while (Done !== 1'b1 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        e = sb.pop_front();
        if (Done !== 1'b1) begin
            check({tag, ".done_timeout"}, 64'(Done), 64'd1);
        end else begin
            check({tag, ".latency"}, 64'(n), 64'(e.lat));
            check({tag, ".HI"}, 64'(HI), 64'(e.hi));
            check({tag, ".LO"}, 64'(LO), 64'(e.lo));
            check({tag, ".W_Data"}, 64'(W_Data), 64'(e.lo));
            check({tag, ".W_Addr"}, 64'(W_Addr), 64'(e.addr));
            check({tag, ".Write_Reg"}, 64'(Write_Reg), 64'(e.wr));
            @(negedge Clk);
            check({tag, ".idle_busy"}, 64'(Busy), 64'd0);
            check({tag, ".idle_wr"}, 64'({Done, Write_Reg}), 64'd0);
            check({tag, ".hold_LO"}, 64'(LO), 64'(e.lo));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int wrs;
        int bsy;
        int done_at;
        vec_t v;
        exp_t e;
        logic [63:0] p;

        vecs[0]  = mk(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 32'h0000_0001);
        vecs[1]  = mk(1'b1, 32'd100,       32'd7,         5'd9,  32'd2,         32'd14);
        vecs[2]  = mk(1'b1, 32'h0000_1234, 32'd0,         5'd3,  32'h0000_1234, 32'hFFFF_FFFF);
        vecs[3]  = mk(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1,  32'd1,         32'd0);
        vecs[4]  = mk(1'b0, 32'd7,         32'd6,         5'd0,  32'd0,         32'd42);
        vecs[5]  = mk(1'b0, 32'h8000_0000, 32'd2,         5'd31, 32'd1,         32'd0);
        vecs[6]  = mk(1'b1, 32'd5,         32'd9,         5'd12, 32'd5,         32'd0);
        vecs[7]  = mk(1'b1, 32'hFFFF_FFFF, 32'd1,         5'd2,  32'd0,         32'hFFFF_FFFF);
        vecs[8]  = mk(1'b1, 32'hFFFF_FFFF, 32'h10,        5'd4,  32'hF,         32'h0FFF_FFFF);
        vecs[9]  = mk(1'b0, 32'h1234_5678, 32'd0,         5'd6,  32'd0,         32'd0);
        vecs[10] = mk(1'b0, 32'hFFFF_FFFF, 32'd2,         5'd7,  32'd1,         32'hFFFF_FFFE);

        Reset_n = 1'b0; Start = 1'b0; Op = 1'b0; Src_A = '0; Src_B = '0; Dst_Addr = '0;
        repeat (2) @(negedge Clk);
        check("rst.outputs", {Busy, Done, Write_Reg, W_Addr, HI, LO}, 64'd0);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst.idle_no_start", {Busy, Done, Write_Reg}, 64'd0);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Random requests checked against arithmetic operators
        for (int i = 0; i < 8; i++) begin
            v.op = i[0];
            v.a = $urandom;
            v.b = $urandom >> $urandom_range(0, 31);
            v.addr = AW'($urandom);
            if (v.op) begin
                if (v.b == 0) v.b = 32'd3;
                v.lo = v.a / v.b;
                v.hi = v.a % v.b;
            end else begin
                p = {32'd0, v.a} * {32'd0, v.b};
                v.hi = p[63:32];
                v.lo = p[31:0];
            end
            v.wr = (v.addr != 0);
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Start pulses at cycles 5 and 33 of a MULTU to register 0
        v = mk(1'b0, 32'd3, 32'd5, 5'd0, 32'd0, 32'd15);
        push_exp(v);
        @(negedge Clk);
        Start = 1'b1; Op = 1'b0; Src_A = v.a; Src_B = v.b; Dst_Addr = v.addr;
        dones = 0; wrs = 0; bsy = 0; done_at = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            Start = (n == 5 || n == 33);
            Src_A = $urandom; Src_B = $urandom; Dst_Addr = 5'd8;
            if (Done === 1'b1) begin
                dones++;
                done_at = n;
                e = sb.pop_front();
                check("ign.HI", 64'(HI), 64'(e.hi));
                check("ign.LO", 64'(LO), 64'(e.lo));
            end
            if (Write_Reg !== 1'b0) wrs++;
            if (n > W + 1 && Busy !== 1'b0) bsy++;
        end
        Start = 1'b0;
        check("ign.done_count", 64'(dones), 64'd1);
        check("ign.done_cycle", 64'(done_at), 64'(W + 1));
        check("ign.write_reg", 64'(wrs), 64'd0);
        check("ign.busy_after", 64'(bsy), 64'd0);

        // Reset asserted at cycle 10 of a MULTU
        @(negedge Clk);
        Start = 1'b1; Op = 1'b0; Src_A = 32'hFFFF_FFFF; Src_B = 32'hFFFF_FFFF; Dst_Addr = 5'd7;
        for (int n = 1; n <= 10; n++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        check("mid.busy_before", 64'(Busy), 64'd1);
        Reset_n = 1'b0;
        #1;
        check("mid.busy", 64'(Busy), 64'd0);
        check("mid.hilo", {HI, LO}, 64'd0);
        check("mid.waddr", 64'(W_Addr), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        wrs = 0; dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (Write_Reg !== 1'b0) wrs++;
            if (Done !== 1'b0) dones++;
        end
        check("mid.no_write", 64'(wrs), 64'd0);
        check("mid.no_done", 64'(dones), 64'd0);
        check("sb.empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
